// File: rtl/alu_hilo_sched_if.sv
// Handshake bundle between the EX stage and the HI/LO multi-cycle sequencer.
interface alu_hilo_sched_if #(
  parameter int FUNC_W = 6
);
  logic              req_valid;
  logic [FUNC_W-1:0] req_func;
  logic              req_ready;
  logic              req_divzero;
  logic              mf_valid;
  logic              mf_stall;
  logic              flush;
  logic              busy;
  logic              commit;
  logic [FUNC_W-1:0] commit_func;
  logic              div_zero;

  modport master (
    output req_valid, req_func, req_divzero, mf_valid, flush,
    input  req_ready, mf_stall, busy, commit, commit_func, div_zero
  );

  modport slave (
    input  req_valid, req_func, req_divzero, mf_valid, flush,
    output req_ready, mf_stall, busy, commit, commit_func, div_zero
  );
endinterface

// File: rtl/alu_hilo_sched.sv
// HI/LO multiply/divide sequencer: holds one op for its latency, then emits a commit strobe.
// Optional ALU_HILO_SCHED_DIVZERO_EN: divide-by-zero ops take a short two-cycle path.
module alu_hilo_sched #(
  parameter int FUNC_W  = 6,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_hilo_sched_if.slave bus
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  localparam logic [FUNC_W-1:0] F_NOP  = FUNC_W'(6'h00);
  localparam logic [FUNC_W-1:0] F_MTHI = FUNC_W'(6'h11);
  localparam logic [FUNC_W-1:0] F_MTLO = FUNC_W'(6'h13);
  localparam logic [FUNC_W-1:0] F_MULS = FUNC_W'(6'h18);
  localparam logic [FUNC_W-1:0] F_MULU = FUNC_W'(6'h19);
  localparam logic [FUNC_W-1:0] F_DIVS = FUNC_W'(6'h1A);
  localparam logic [FUNC_W-1:0] F_DIVU = FUNC_W'(6'h1B);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_COMMIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic              dz_q, dz_d;

  logic              is_mul, is_div, is_mt, accept;
  logic [CNT_W-1:0]  load;

  assign is_mul = (bus.req_func == F_MULS) || (bus.req_func == F_MULU);
  assign is_div = (bus.req_func == F_DIVS) || (bus.req_func == F_DIVU);
  assign is_mt  = (bus.req_func == F_MTHI) || (bus.req_func == F_MTLO);

  assign bus.req_ready   = (state_q == ST_IDLE) && !bus.flush;
  assign accept          = bus.req_valid && bus.req_ready && (is_mul || is_div || is_mt);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.commit      = (state_q == ST_COMMIT);
  assign bus.commit_func = bus.commit ? func_q : F_NOP;
  assign bus.div_zero    = bus.commit && dz_q;
  assign bus.mf_stall    = bus.mf_valid && (bus.busy || (bus.req_valid && bus.req_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      func_q  <= F_NOP;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      func_q  <= func_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    func_d  = func_q;
    dz_d    = dz_q;
    load    = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          func_d = bus.req_func;
          dz_d   = 1'b0;
          if (is_mul)      load = CNT_W'(MUL_LAT - 1);
          else if (is_div) load = CNT_W'(DIV_LAT - 1);
`ifdef ALU_HILO_SCHED_DIVZERO_EN
          if (is_div && bus.req_divzero) begin
            load = CNT_W'(1);
            dz_d = 1'b1;
          end
`endif
          // A zero load covers Mt* as well as single-cycle latencies.
          cnt_d   = load;
          state_d = (load == '0) ? ST_COMMIT : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          func_d  = F_NOP;
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // Flush is ignored here: the committing op is older than the flush point.
        state_d = ST_IDLE;
        cnt_d   = '0;
        func_d  = F_NOP;
        dz_d    = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule
